// File: rtl/control_unit.sv
// control_unit: Moore control sequencer generating datapath, ALU and memory strobes from fetch/decode/execute states.
module control_unit #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [31:0]     IR,
  input  logic            Mem_ready,
  input  logic            Stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            ZLOout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            Read,
  output logic            Write,
  output logic [ALUW-1:0] ALUop,
  output logic            Run,
  output logic            Clear
);
  typedef enum logic [4:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3,
    S_A1, S_A2, S_WB, S_I1, S_I2, S_N1,
    S_L1, S_L2, S_L3, S_L4, S_L5,
    S_S1, S_S2, S_S3, S_S4, S_S5, S_HALT
  } state_t;
  state_t state_q, state_d, fin;
  logic [ALUW-1:0] alu_q, alu_d;
  logic [OPW-1:0] opc;
  logic unused_ir;
  assign opc = IR[31:32-OPW];
  assign unused_ir = ^IR[31-OPW:0];
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_RST;
      alu_q <= '0;
    end else begin
      state_q <= state_d;
      alu_q <= alu_d;
    end
  end
  // ALU function is captured at decode so E2 stays a pure function of registers
  always_comb begin
    alu_d = state_q != S_T3 ? alu_q
          : opc == 5'b00100 ? ALUW'(1)
          : (opc == 5'b00101 || opc == 5'b01001) ? ALUW'(2)
          : (opc == 5'b00110 || opc == 5'b01010) ? ALUW'(3)
          : '0;
  end
  always_comb begin
    fin = Stop ? S_HALT : S_T0;
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T1W;
      S_T1W:  state_d = Mem_ready ? S_T2 : S_T1W;
      S_T2:   state_d = S_T3;
      S_T3:
        case (opc)
          5'b00011, 5'b00100, 5'b00101, 5'b00110: state_d = S_A1;
          5'b01000, 5'b01001, 5'b01010:           state_d = S_I1;
          5'b10001:                               state_d = S_N1;
          5'b00000:                               state_d = S_L1;
          5'b00010:                               state_d = S_S1;
          5'b11100:                               state_d = S_HALT;
          default:                                state_d = fin;
        endcase
      S_A1:   state_d = S_A2;
      S_A2:   state_d = S_WB;
      S_WB:   state_d = fin;
      S_I1:   state_d = S_I2;
      S_I2:   state_d = S_WB;
      S_N1:   state_d = S_WB;
      S_L1:   state_d = S_L2;
      S_L2:   state_d = S_L3;
      S_L3:   state_d = S_L4;
      S_L4:   state_d = Mem_ready ? S_L5 : S_L4;
      S_L5:   state_d = fin;
      S_S1:   state_d = S_S2;
      S_S2:   state_d = S_S3;
      S_S3:   state_d = S_S4;
      S_S4:   state_d = S_S5;
      S_S5:   state_d = Mem_ready ? fin : S_S5;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end
  assign PCout  = state_q == S_T0;
  assign IncPC  = state_q == S_T0;
  assign PCin   = state_q == S_T1;
  assign IRin   = state_q == S_T2;
  assign Grc    = state_q == S_A2;
  assign Write  = state_q == S_S5;
  assign MARin  = state_q inside {S_T0, S_L3, S_S3};
  assign Zin    = state_q inside {S_T0, S_A2, S_I2, S_N1, S_L2, S_S2};
  assign ZLOout = state_q inside {S_T1, S_WB, S_L3, S_S3};
  assign Read   = state_q inside {S_T1W, S_L4};
  assign MDRin  = state_q inside {S_T1W, S_L4, S_S4};
  assign MDRout = state_q inside {S_T2, S_L5};
  assign Yin    = state_q inside {S_A1, S_I1, S_L1, S_S1};
  assign Grb    = state_q inside {S_A1, S_I1, S_N1, S_L1, S_S1};
  assign Gra    = state_q inside {S_WB, S_L5, S_S4};
  assign Rout   = state_q inside {S_A1, S_A2, S_I1, S_N1, S_S4};
  assign Rin    = state_q inside {S_WB, S_L5};
  assign BAout  = state_q inside {S_L1, S_S1};
  assign Cout   = state_q inside {S_I2, S_L2, S_S2};
  assign ALUop  = state_q inside {S_A2, S_I2} ? alu_q : state_q == S_N1 ? ALUW'(4) : '0;
  assign Run    = !(state_q inside {S_RST, S_HALT});
  assign Clear  = state_q == S_RST;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench comparing every control output per state against hand-built vectors.
module tb_control_unit;
  logic Clock = 0, Resetn = 1, Mem_ready = 1, Stop = 0;
  logic [31:0] IR = '0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Read, Write, Run, Clear;
  logic [3:0] ALUop;
  logic [24:0] vec;
  int n_tests = 0, n_fail = 0;
  localparam logic [24:0] CLEAR = 25'd1, RUN = 25'd1 << 1, WRITE = 25'd1 << 2, READ = 25'd1 << 3;
  localparam logic [24:0] COUT = 25'd1 << 4, BAOUT = 25'd1 << 5, ROUT = 25'd1 << 6, RIN = 25'd1 << 7;
  localparam logic [24:0] GRC = 25'd1 << 8, GRB = 25'd1 << 9, GRA = 25'd1 << 10, ZLOOUT = 25'd1 << 11;
  localparam logic [24:0] ZIN = 25'd1 << 12, YIN = 25'd1 << 13, IRIN = 25'd1 << 14, MDROUT = 25'd1 << 15;
  localparam logic [24:0] MDRIN = 25'd1 << 16, MARIN = 25'd1 << 17, INCPC = 25'd1 << 18, PCIN = 25'd1 << 19;
  localparam logic [24:0] PCOUT = 25'd1 << 20;
  localparam logic [24:0] OP1 = 25'd1 << 21, OP2 = 25'd2 << 21, OP3 = 25'd3 << 21, OP4 = 25'd4 << 21;
  localparam logic [24:0] X_T0 = RUN | PCOUT | MARIN | INCPC | ZIN, X_T1 = RUN | ZLOOUT | PCIN;
  localparam logic [24:0] X_T1W = RUN | READ | MDRIN, X_T2 = RUN | MDROUT | IRIN;
  localparam logic [24:0] X_RB = RUN | GRB | ROUT | YIN, X_WB = RUN | ZLOOUT | GRA | RIN;
  localparam logic [24:0] X_BA = RUN | GRB | BAOUT | YIN, X_CA = RUN | COUT | ZIN, X_MA = RUN | ZLOOUT | MARIN;
  control_unit dut (
    .Clock(Clock), .Resetn(Resetn), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .Read(Read), .Write(Write),
    .ALUop(ALUop), .Run(Run), .Clear(Clear)
  );
  assign vec = {ALUop, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout,
                Gra, Grb, Grc, Rin, Rout, BAout, Cout, Read, Write, Run, Clear};
  always #5 Clock = ~Clock;
  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [24:0] exp);
    check(tag, vec, exp);
    @(posedge Clock);
    #1;
  endtask
  task automatic do_reset;
    Resetn = 0;
    #1 check("rst_async", vec, CLEAR);
    @(negedge Clock);
    Resetn = 1;
    #1 check("rst_hold", vec, CLEAR);
    @(posedge Clock);
    #1;
  endtask
  task automatic fetch(input logic [31:0] ir, input int stall);
    step("t0", X_T0);
    step("t1", X_T1);
    Mem_ready = 0;
    for (int i = 0; i < stall; i++) step("t1w_stall", X_T1W);
    Mem_ready = 1;
    step("t1w", X_T1W);
    IR = ir;
    step("t2", X_T2);
    step("t3", RUN);
  endtask
  initial begin
    #3 do_reset();
    fetch(32'h19918000, 0);
    step("add_e1", X_RB);
    step("add_e2", RUN | GRC | ROUT | ZIN);
    step("add_e3", X_WB);
    fetch(32'h20000000, 0);
    step("sub_e1", X_RB);
    step("sub_e2", RUN | GRC | ROUT | ZIN | OP1);
    step("sub_e3", X_WB);
    fetch(32'h30000000, 0);
    step("or_e1", X_RB);
    step("or_e2", RUN | GRC | ROUT | ZIN | OP3);
    step("or_e3", X_WB);
    fetch(32'h88918000, 0);
    step("not_e1", RUN | GRB | ROUT | ZIN | OP4);
    step("not_e2", X_WB);
    fetch(32'h48000000, 0);
    step("andi_e1", X_RB);
    step("andi_e2", X_CA | OP2);
    step("andi_e3", X_WB);
    fetch(32'h50000000, 0);
    step("ori_e1", X_RB);
    step("ori_e2", X_CA | OP3);
    step("ori_e3", X_WB);
    fetch(32'h00800005, 0);
    step("ld_e1", X_BA);
    step("ld_e2", X_CA);
    step("ld_e3", X_MA);
    Mem_ready = 0;
    for (int i = 0; i < 3; i++) step("ld_e4_wait", RUN | READ | MDRIN);
    Mem_ready = 1;
    step("ld_e4", RUN | READ | MDRIN);
    step("ld_e5", RUN | MDROUT | GRA | RIN);
    fetch(32'h10800005, 0);
    step("st_e1", X_BA);
    step("st_e2", X_CA);
    step("st_e3", X_MA);
    step("st_e4", RUN | GRA | ROUT | MDRIN);
    step("st_e5", RUN | WRITE);
    fetch(32'hD8000000, 2);
    fetch(32'hF8000000, 0);
    fetch(32'h19918000, 0);
    step("stop_e1", X_RB);
    Stop = 1;
    step("stop_e2", RUN | GRC | ROUT | ZIN);
    step("stop_e3", X_WB);
    Stop = 0;
    for (int i = 0; i < 5; i++) step("stop_halt", '0);
    do_reset();
    fetch(32'hE0000000, 0);
    for (int i = 0; i < 20; i++) step("halt", '0);
    do_reset();
    fetch(32'h00800005, 0);
    step("ldr_e1", X_BA);
    step("ldr_e2", X_CA);
    step("ldr_e3", X_MA);
    Mem_ready = 0;
    check("ldr_e4_wait", vec, RUN | READ | MDRIN);
    #2 do_reset();
    Mem_ready = 1;
    step("after_rst_t0", X_T0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
